// File: rtl/pattern_loader.sv
// Byte-stream command parser feeding the serial output stage: double-buffered
// output/frequency pattern loads, start/stop/mode control and busy tracking.
module pattern_loader #(
  parameter int DATA_BIT       = 32,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          i_rx_data,
  input  logic                i_rx_done_tick,
  input  logic                i_done_tick,
  output logic [DATA_BIT-1:0] o_output_pattern,
  output logic [DATA_BIT-1:0] o_freq_pattern,
  output logic                o_mode,
  output logic                o_start,
  output logic                o_stop,
  output logic                o_busy,
  output logic                o_cmd_err,
  output logic                o_timeout
);

  localparam int NBYTES = DATA_BIT / 8;
  localparam int CW     = $clog2(NBYTES) + 1;
  localparam int TW     = $clog2(TIMEOUT_CYCLES);

  typedef enum logic {S_CMD, S_DATA} state_t;

  state_t              state_q, state_d;
  logic [DATA_BIT-1:0] shadow_q, shadow_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                tgt_q, tgt_d;
  logic [DATA_BIT-1:0] out_pat_q, out_pat_d;
  logic [DATA_BIT-1:0] freq_pat_q, freq_pat_d;
  logic                mode_q, mode_d;
  logic                start_q, start_d;
  logic                stop_q, stop_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                tout_q, tout_d;

  logic                is_load, last_byte, expire, busy_eff;
  logic [DATA_BIT-1:0] shifted;

  assign is_load   = (i_rx_data == 8'h01) || (i_rx_data == 8'h02);
  assign last_byte = i_rx_done_tick && (cnt_q == CW'(NBYTES - 1));
  assign expire    = !i_rx_done_tick && (timer_q == TW'(TIMEOUT_CYCLES - 1));
  // A one-shot finishing this cycle frees the stage for a start in the same cycle.
  assign busy_eff  = busy_q && !(i_done_tick && !mode_q);
  assign shifted   = {i_rx_data, shadow_q[DATA_BIT-1:8]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_CMD;
      shadow_q   <= '0;
      cnt_q      <= '0;
      timer_q    <= '0;
      tgt_q      <= 1'b0;
      out_pat_q  <= '0;
      freq_pat_q <= '0;
      mode_q     <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      tout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      tgt_q      <= tgt_d;
      out_pat_q  <= out_pat_d;
      freq_pat_q <= freq_pat_d;
      mode_q     <= mode_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      tout_q     <= tout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CMD:   if (i_rx_done_tick && is_load) state_d = S_DATA;
      S_DATA:  if (last_byte || expire)       state_d = S_CMD;
      default: state_d = S_CMD;
    endcase
  end

  always_comb begin
    shadow_d   = shadow_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
    tgt_d      = tgt_q;
    out_pat_d  = out_pat_q;
    freq_pat_d = freq_pat_q;
    mode_d     = mode_q;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    busy_d     = busy_eff;
    err_d      = 1'b0;
    tout_d     = 1'b0;
    case (state_q)
      S_CMD: begin
        if (i_rx_done_tick) begin
          case (i_rx_data)
            8'h01, 8'h02: begin
              tgt_d    = i_rx_data[1];
              cnt_d    = '0;
              timer_d  = '0;
              shadow_d = '0;
            end
            8'h03, 8'h04: begin
              if (busy_eff) begin
                err_d = 1'b1;
              end else begin
                start_d = 1'b1;
                mode_d  = i_rx_data[2];
                busy_d  = 1'b1;
              end
            end
            8'h05: begin
              stop_d = 1'b1;
              busy_d = 1'b0;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      S_DATA: begin
        if (i_rx_done_tick) begin
          shadow_d = shifted;
          cnt_d    = cnt_q + 1'b1;
          timer_d  = '0;
          if (last_byte) begin
            if (tgt_q) freq_pat_d = shifted;
            else       out_pat_d  = shifted;
          end
        end else if (expire) begin
          shadow_d = '0;
          timer_d  = '0;
          tout_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign o_output_pattern = out_pat_q;
  assign o_freq_pattern   = freq_pat_q;
  assign o_mode           = mode_q;
  assign o_start          = start_q;
  assign o_stop           = stop_q;
  assign o_busy           = busy_q;
  assign o_cmd_err        = err_q;
  assign o_timeout        = tout_q;

endmodule
